// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply-divide unit for the EX stage.
// Define MDU_MSUB_EN to enable msub (MD_ctr=111); otherwise that encoding is ignored.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MD_ctr,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HIO,
    output logic [31:0] LOO
);
`ifdef MDU_MSUB_EN
    localparam logic MSUB = 1'b1;
`else
    localparam logic MSUB = 1'b0;
`endif
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] hi_n, lo_n;
    logic [63:0] res, res_n;
    logic        wr, wr_n;
    logic [63:0] acc, ps, pu, calc;
    logic [31:0] ua, ub, ubs, sq, sr, squo, srem, udv, uquo, urem;
    logic        is_div, legal;
    logic [3:0]  n_ld;
    assign acc    = {HIO, LOO};
    assign ps     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign pu     = {32'b0, A} * {32'b0, B};
    // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow corner.
    assign ua     = A[31] ? -A : A;
    assign ub     = B[31] ? -B : B;
    assign ubs    = (ub == 32'd0) ? 32'd1 : ub;
    assign sq     = ua / ubs;
    assign sr     = ua % ubs;
    assign squo   = (A[31] ^ B[31]) ? -sq : sq;
    assign srem   = A[31] ? -sr : sr;
    assign udv    = (B == 32'd0) ? 32'd1 : B;
    assign uquo   = A / udv;
    assign urem   = A % udv;
    assign is_div = MD_ctr[2:1] == 2'b01;
    assign legal  = (MD_ctr inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b110}) || (MD_ctr == 3'b111 && MSUB);
    assign n_ld   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    assign calc   = MD_ctr == 3'b000 ? ps :
                    MD_ctr == 3'b001 ? pu :
                    MD_ctr == 3'b010 ? {srem, squo} :
                    MD_ctr == 3'b011 ? {urem, uquo} :
                    MD_ctr == 3'b110 ? acc + ps : acc - ps;
    assign Busy   = state == RUN;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hi_n    = HIO;
        lo_n    = LOO;
        res_n   = res;
        wr_n    = wr;
        if (state == IDLE) begin
            if (Start && legal) begin
                state_n = RUN;
                cnt_n   = n_ld;
                res_n   = calc;
                wr_n    = !(is_div && B == 32'd0);
            end else if (!Start) begin
                hi_n = (MD_ctr == 3'b100) ? A : HIO;
                lo_n = (MD_ctr == 3'b101) ? A : LOO;
            end
        end else if (cnt == 4'd1) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
            wr_n    = 1'b0;
            hi_n    = wr ? res[63:32] : HIO;
            lo_n    = wr ? res[31:0] : LOO;
        end else begin
            cnt_n = cnt - 4'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            HIO   <= 32'd0;
            LOO   <= 32'd0;
            res   <= 64'd0;
            wr    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            HIO   <= hi_n;
            LOO   <= lo_n;
            res   <= res_n;
            wr    <= wr_n;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  MD_ctr = 3'b000;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Busy;
    logic [31:0] HIO, LOO;
    int total = 0;
    int bad = 0;
    mult_div_unit dut (
        .clk(clk), .reset(reset), .Start(Start), .MD_ctr(MD_ctr),
        .A(A), .B(B), .Busy(Busy), .HIO(HIO), .LOO(LOO)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        Start = 1'b1; MD_ctr = op; A = a; B = b;
        tick();
        Start = 1'b0; MD_ctr = 3'b000; A = 32'd0; B = 32'd0;
        chk({tag, "_busy_rise"}, 32'(Busy), 32'd1);
    endtask
    task automatic wait_commit(input int n, input logic [31:0] hi, input logic [31:0] lo, input string tag);
        for (int i = 1; i < n; i++) begin
            tick();
            chk({tag, "_busy_hold"}, 32'(Busy), 32'd1);
        end
        tick();
        chk({tag, "_busy_fall"}, 32'(Busy), 32'd0);
        chk({tag, "_hi"}, HIO, hi);
        chk({tag, "_lo"}, LOO, lo);
    endtask
    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        MD_ctr = op; A = a;
        tick();
        MD_ctr = 3'b000; A = 32'd0;
    endtask
    initial begin
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_hi", HIO, 32'd0);
        chk("rst_lo", LOO, 32'd0);
        launch(3'b000, 32'hFFFFFFFE, 32'd3, "mult");
        wait_commit(5, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
        launch(3'b001, 32'hFFFFFFFE, 32'd3, "multu");
        wait_commit(5, 32'h00000002, 32'hFFFFFFFA, "multu");
        launch(3'b010, 32'hFFFFFFF9, 32'd2, "div");
        wait_commit(10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
        launch(3'b011, 32'd7, 32'd2, "divu");
        wait_commit(10, 32'd1, 32'd3, "divu");
        mt(3'b100, 32'h12345678);
        mt(3'b101, 32'h00000000);
        chk("mthi", HIO, 32'h12345678);
        chk("mtlo", LOO, 32'h00000000);
        launch(3'b010, 32'd99, 32'd0, "div0");
        wait_commit(10, 32'h12345678, 32'h00000000, "div0");
        launch(3'b010, 32'h80000000, 32'hFFFFFFFF, "divovf");
        wait_commit(10, 32'h00000000, 32'h80000000, "divovf");
        mt(3'b100, 32'h00000000);
        mt(3'b101, 32'hFFFFFFFF);
        launch(3'b110, 32'd1, 32'd1, "madd");
        wait_commit(5, 32'd1, 32'd0, "madd");
`ifdef MDU_MSUB_EN
        launch(3'b111, 32'd1, 32'd1, "msub");
        wait_commit(5, 32'd0, 32'hFFFFFFFF, "msub");
`else
        Start = 1'b1; MD_ctr = 3'b111; A = 32'd5; B = 32'd5;
        tick();
        Start = 1'b0; MD_ctr = 3'b000; A = 32'd0; B = 32'd0;
        chk("msub_off_busy", 32'(Busy), 32'd0);
        chk("msub_off_hi", HIO, 32'd1);
        chk("msub_off_lo", LOO, 32'd0);
`endif
        Start = 1'b1; MD_ctr = 3'b100; A = 32'hDEADBEEF;
        tick();
        Start = 1'b0; MD_ctr = 3'b000; A = 32'd0;
        chk("start_mthi_busy", 32'(Busy), 32'd0);
        chk("start_mthi_hi", HIO, 32'(`ifdef MDU_MSUB_EN 0 `else 1 `endif));
        launch(3'b000, 32'd6, 32'd7, "poke");
        tick();
        Start = 1'b1; MD_ctr = 3'b010; A = 32'd100; B = 32'd3;
        tick();
        Start = 1'b0; MD_ctr = 3'b100; A = 32'hDEADBEEF;
        tick();
        MD_ctr = 3'b000; A = 32'd0; B = 32'd0;
        wait_commit(2, 32'd0, 32'd42, "poke");
        tick();
        chk("poke_idle", 32'(Busy), 32'd0);
        launch(3'b000, 32'd5, 32'd5, "abort");
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_hi", HIO, 32'd0);
        chk("abort_lo", LOO, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("abort_late_busy", 32'(Busy), 32'd0);
        chk("abort_late_lo", LOO, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
